// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package seg_display_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam int              MAX_DIGITS = 8;
  localparam logic [7:0]      SEG_OFF    = 8'hFF;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Active-low {g,f,e,d,c,b,a} codes, indexed by hex value (entry 0 is last).
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble plus decimal-point enable to active-low {dp,g,f,e,d,c,b,a}.
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp_on,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp_on, SEG7_TABLE[i_nib]};

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot
// and an all-dark blanking gap ahead of every digit slot.
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 4
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLANK_CYCLES - 1);

  state_t                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx,   w_idx_nxt;
  logic [CNT_W-1:0]         r_cnt,   w_cnt_nxt;
  logic                     w_snap;

  logic [4*NUM_DIGITS-1:0]  r_snap_data;
  logic [NUM_DIGITS-1:0]    r_snap_en;
  logic [NUM_DIGITS-1:0]    r_snap_dp;

  logic [3:0]               w_nib;
  logic                     w_en;
  logic                     w_dp;
  logic                     w_lit;
  logic                     w_frame;
  logic [NUM_DIGITS-1:0]    w_an;
  logic [7:0]               w_seg;

  // State, slot index and blank counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: ticks advance the slot from S_OFF/S_SHOW; ticks in S_BLANK are dropped
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_snap      = 1'b0;
    case (r_state)
      S_OFF: begin
        if (tick) begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_snap      = 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (tick) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_snap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  // Frame snapshot, taken on the edge that enters digit 0's blanking gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_data <= '0;
      r_snap_en   <= '0;
      r_snap_dp   <= '0;
    end else if (w_snap) begin
      r_snap_data <= data;
      r_snap_en   <= digit_en;
      r_snap_dp   <= dp_en;
    end
  end

  // Select the current digit's snapshot fields and build the anode pattern
  always_comb begin
    w_nib = '0;
    w_en  = 1'b0;
    w_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib = r_snap_data[i*4 +: 4];
        w_en  = r_snap_en[i];
        w_dp  = r_snap_dp[i];
      end
    end
    // A disabled digit still consumes its slot, just dark
    w_lit   = (r_state == S_SHOW) && w_en;
    w_frame = (r_state == S_BLANK) && (r_idx == '0) && (r_cnt == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an[i] = !(w_lit && (r_idx == IDX_W'(i)));
    end
  end

  seg_hex_decode u_dec (
    .i_nib   (w_nib),
    .i_dp_on (w_dp),
    .o_seg   (w_seg)
  );

  // Registered display outputs; reset blanks them immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF[NUM_DIGITS-1:0];
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      an          <= w_an;
      seg         <= w_lit ? w_seg : SEG_OFF;
      frame_start <= w_frame;
    end
  end

endmodule
